// File: rtl/dmem_sram_responder.sv
// ---------------------------------------------------------------------------
// dmem_sram_responder
//
// Data-side memory responder for the 5-stage pipeline. It takes the M-stage
// load/store request and runs it as one split address/data transaction on an
// SRAM-like bus. While the access is in flight it raises d_stall. The finished
// result is held in HOLD until the global stall releases, so one M-stage access
// is never issued twice.
//
// Optional feature: define DMEM_TIMEOUT_EN to enable the watchdog. When the
// watchdog fires, the transaction ends with readdataM = 32'hDEAD_BEEF and a
// sticky bus_err. With the macro undefined there is no counter, the block waits
// indefinitely, and bus_err is tied to 0.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   mem_enM          M-stage instruction is a load or a store
//   memwriteM        1 = store, 0 = load
//   sig_write[3:0]   store byte strobes
//   aluoutM[AW-1:0]  access address
//   writedataM[31:0] lane-aligned store data
//   longest_stall    global pipeline stall
//   readdataM[31:0]  registered load data
//   d_stall          stall request to the hazard unit
//   data_req         bus request valid
//   data_wr          bus write
//   data_wstrb[3:0]  bus byte strobes (0000 on loads)
//   data_addr        bus address
//   data_wdata       bus write data
//   data_addr_ok     bus accepted the request
//   data_data_ok     bus returned data / write ack
//   data_rdata       bus read data
//   bus_err          sticky watchdog error
// ---------------------------------------------------------------------------
module dmem_sram_responder #(
   parameter int AW          = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_enM,
   input  logic          memwriteM,
   input  logic [3:0]    sig_write,
   input  logic [AW-1:0] aluoutM,
   input  logic [31:0]   writedataM,
   input  logic          longest_stall,
   output logic [31:0]   readdataM,
   output logic          d_stall,
   output logic          data_req,
   output logic          data_wr,
   output logic [3:0]    data_wstrb,
   output logic [AW-1:0] data_addr,
   output logic [31:0]   data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [31:0]   data_rdata,
   output logic          bus_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   logic [1:0] state;
   logic       busy;
   logic       done;
   logic       tmo;

   assign busy = (state == ADDR) || (state == DATA);

   // A transaction completes when data_ok arrives in DATA, or when addr_ok and
   // data_ok arrive together in ADDR.
   assign done = ((state == DATA) && data_data_ok) ||
                 ((state == ADDR) && data_addr_ok && data_data_ok);

   assign data_req = (state == ADDR);
   assign d_stall  = !rst && (((state == IDLE) && mem_enM) || busy);

`ifdef DMEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          err;

   assign cnt_nxt = cnt + 1'b1;
   // The watchdog fires on the edge at which the count of busy cycles reaches
   // TIMEOUT_CYC. A transaction that completes on that same edge wins.
   assign tmo     = busy && !done && (cnt_nxt == CW'(TIMEOUT_CYC));
   assign bus_err = err;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (busy) begin
            cnt <= cnt_nxt;
         end else if (state == HOLD) begin
            // Clear before re-entering IDLE so the next access starts at zero.
            cnt <= '0;
         end
         if (tmo) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign tmo     = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         data_wr    <= 1'b0;
         data_wstrb <= 4'b0000;
         data_addr  <= '0;
         data_wdata <= '0;
         readdataM  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_enM) begin
                  data_addr  <= aluoutM;
                  data_wr    <= memwriteM;
                  data_wdata <= writedataM;
                  data_wstrb <= memwriteM ? sig_write : 4'b0000;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (data_addr_ok) begin
                  if (data_data_ok) begin
                     state <= HOLD;
                     if (!data_wr) begin
                        readdataM <= data_rdata;
                     end
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (data_data_ok) begin
                  state <= HOLD;
                  if (!data_wr) begin
                     readdataM <= data_rdata;
                  end
               end
            end
            default: begin
               // HOLD: keep the result until the pipeline is allowed to advance.
               if (!longest_stall) begin
                  state <= IDLE;
               end
            end
         endcase
         if (tmo) begin
            state     <= HOLD;
            readdataM <= 32'hDEAD_BEEF;
         end
      end
   end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_sram_responder
//
// Directed bench for dmem_sram_responder. A per-cycle table covers the load,
// store, combined-handshake, held-result and wait-state cases. Hand-written
// sequences cover reset in the middle of a transaction and, when
// DMEM_TIMEOUT_EN is defined, the watchdog.
// ---------------------------------------------------------------------------
module tb_dmem_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_enM, memwriteM, longest_stall;
   logic [3:0]  sig_write;
   logic [31:0] aluoutM, writedataM;
   logic [31:0] readdataM;
   logic        d_stall, data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_sram_responder #(.AW(32), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .mem_enM(mem_enM), .memwriteM(memwriteM),
      .sig_write(sig_write), .aluoutM(aluoutM), .writedataM(writedataM),
      .longest_stall(longest_stall), .readdataM(readdataM), .d_stall(d_stall),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata), .bus_err(bus_err)
   );

   typedef struct {
      logic        men;
      logic        mw;
      logic [3:0]  sw;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        ls;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
      logic        e_stall;
      logic        e_req;
      logic        e_wr;
      logic [3:0]  e_strb;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_rdm;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic men, input logic mw, input logic [3:0] sw,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic ls, input logic aok, input logic dok,
                      input logic [31:0] rd, input logic e_stall, input logic e_req,
                      input logic e_wr, input logic [3:0] e_strb,
                      input logic [31:0] e_addr, input logic [31:0] e_wdata,
                      input logic [31:0] e_rdm);
      vec_t v;
      v.men = men; v.mw = mw; v.sw = sw; v.addr = addr; v.wd = wd;
      v.ls = ls; v.aok = aok; v.dok = dok; v.rd = rd;
      v.e_stall = e_stall; v.e_req = e_req; v.e_wr = e_wr; v.e_strb = e_strb;
      v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdm = e_rdm;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic men, input logic mw, input logic [3:0] sw,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic ls, input logic aok, input logic dok,
                        input logic [31:0] rd);
      mem_enM = men; memwriteM = mw; sig_write = sw; aluoutM = addr;
      writedataM = wd; longest_stall = ls; data_addr_ok = aok;
      data_data_ok = dok; data_rdata = rd;
   endtask

   initial begin
      // One row per clock cycle. The inputs are applied, the outputs are
      // checked in the same cycle, and then the clock advances.
      // T1: load, addr_ok in ADDR, data_ok one cycle later -> 3 stall cycles
      add(1,0,4'hF,32'h100,0,          0,0,0,0,            1,0,0,4'h0,32'h0,  32'h0, 32'h0);
      add(1,0,4'hF,32'h100,0,          1,1,0,0,            1,1,0,4'h0,32'h100,32'h0, 32'h0);
      add(1,0,4'hF,32'h100,0,          1,0,1,32'h12345678, 1,0,0,4'h0,32'h100,32'h0, 32'h0);
      add(1,0,4'hF,32'h100,0,          0,0,0,0,            0,0,0,4'h0,32'h100,32'h0, 32'h12345678);
      // T2: store, readdataM unchanged, strobes 0100
      add(1,1,4'h4,32'h80000004,32'h00AB0000, 0,0,0,0,            1,0,0,4'h0,32'h100,       32'h0,        32'h12345678);
      add(1,1,4'h4,32'h80000004,32'h00AB0000, 1,1,0,0,            1,1,1,4'h4,32'h80000004,32'h00AB0000,32'h12345678);
      add(1,1,4'h4,32'h80000004,32'h00AB0000, 1,0,1,32'hFFFFFFFF, 1,0,1,4'h4,32'h80000004,32'h00AB0000,32'h12345678);
      add(0,0,4'h0,32'h0,0,                   0,0,0,0,            0,0,1,4'h4,32'h80000004,32'h00AB0000,32'h12345678);
      // Stray addr_ok/data_ok in IDLE are ignored
      add(0,0,4'h0,32'h0,0,                   0,1,1,32'h55555555, 0,0,1,4'h4,32'h80000004,32'h00AB0000,32'h12345678);
      // T3: addr_ok and data_ok together -> 2 stall cycles
      add(1,0,4'h0,32'h200,0,          0,0,0,0,            1,0,1,4'h4,32'h80000004,32'h00AB0000,32'h12345678);
      add(1,0,4'h0,32'h200,0,          1,1,1,32'hCAFEF00D, 1,1,0,4'h0,32'h200,32'h0,32'h12345678);
      // T4: longest_stall held for 5 cycles, bus noise ignored
      for (int i = 0; i < 5; i++)
         add(1,0,4'h0,32'h200,0,       1,1,1,32'h0,        0,0,0,4'h0,32'h200,32'h0,32'hCAFEF00D);
      add(1,0,4'h0,32'h200,0,          0,0,0,0,            0,0,0,4'h0,32'h200,32'h0,32'hCAFEF00D);
      // Back in IDLE, a new load with slave wait states
      add(1,0,4'h0,32'h300,32'h11111111, 0,0,0,0,            1,0,0,4'h0,32'h200,32'h0,       32'hCAFEF00D);
      add(1,0,4'h0,32'h300,32'h11111111, 1,0,0,0,            1,1,0,4'h0,32'h300,32'h11111111,32'hCAFEF00D);
      add(1,0,4'h0,32'h300,32'h11111111, 1,1,0,0,            1,1,0,4'h0,32'h300,32'h11111111,32'hCAFEF00D);
      add(1,0,4'h0,32'h300,32'h11111111, 1,0,0,0,            1,0,0,4'h0,32'h300,32'h11111111,32'hCAFEF00D);
      add(1,0,4'h0,32'h300,32'h11111111, 1,0,1,32'h0BADF00D, 1,0,0,4'h0,32'h300,32'h11111111,32'hCAFEF00D);
      add(0,0,4'h0,32'h0,0,              0,0,0,0,            0,0,0,4'h0,32'h300,32'h11111111,32'h0BADF00D);
      add(0,0,4'h0,32'h0,0,              0,0,0,0,            0,0,0,4'h0,32'h300,32'h11111111,32'h0BADF00D);

      // Reset. d_stall is forced low while rst is high.
      rst = 1'b1;
      drive(1,0,4'h0,32'h0,0,0,0,0,0);
      tick();
      tick();
      chk("rst_dstall_forced", {31'b0, d_stall}, 32'h0);
      drive(0,0,4'h0,32'h0,0,0,0,0,0);
      rst = 1'b0;
      #1;
      chk("rst_readdata", readdataM, 32'h0);
      chk("rst_req", {31'b0, data_req}, 32'h0);
      chk("rst_addr", data_addr, 32'h0);
      chk("rst_buserr", {31'b0, bus_err}, 32'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].men, vecs[i].mw, vecs[i].sw, vecs[i].addr, vecs[i].wd,
               vecs[i].ls, vecs[i].aok, vecs[i].dok, vecs[i].rd);
         #1;
         chk($sformatf("v%0d_dstall", i), {31'b0, d_stall}, {31'b0, vecs[i].e_stall});
         chk($sformatf("v%0d_req", i),    {31'b0, data_req}, {31'b0, vecs[i].e_req});
         chk($sformatf("v%0d_wr", i),     {31'b0, data_wr}, {31'b0, vecs[i].e_wr});
         chk($sformatf("v%0d_wstrb", i),  {28'b0, data_wstrb}, {28'b0, vecs[i].e_strb});
         chk($sformatf("v%0d_addr", i),   data_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_wdata", i),  data_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_rdata", i),  readdataM, vecs[i].e_rdm);
         chk($sformatf("v%0d_buserr", i), {31'b0, bus_err}, 32'h0);
         tick();
      end

      // T5: reset while in DATA aborts to IDLE
      drive(1,0,4'h0,32'h400,32'h44444444,0,0,0,0);
      tick();                                   // now ADDR
      drive(1,0,4'h0,32'h400,32'h44444444,1,1,0,0);
      tick();                                   // now DATA
      drive(1,0,4'h0,32'h400,32'h44444444,1,0,0,0);
      #1;
      chk("t5_data_req", {31'b0, data_req}, 32'h0);
      chk("t5_data_stall", {31'b0, d_stall}, 32'h1);
      rst = 1'b1;
      drive(0,0,4'h0,32'h0,0,0,0,0,0);
      tick();
      rst = 1'b0;
      drive(0,0,4'h0,32'h0,0,0,0,1,32'h77777777);   // stale data_ok is ignored
      #1;
      chk("t5_req", {31'b0, data_req}, 32'h0);
      chk("t5_stall", {31'b0, d_stall}, 32'h0);
      chk("t5_readdata", readdataM, 32'h0);
      chk("t5_addr", data_addr, 32'h0);
      tick();
      chk("t5_stale_ignored", readdataM, 32'h0);
      drive(1,0,4'h0,32'h400,0,0,0,0,0);
      #1;
      chk("t5_idle_stall", {31'b0, d_stall}, 32'h1);
      tick();
      drive(1,0,4'h0,32'h400,0,1,1,1,32'h77777777);
      #1;
      chk("t5_reissue_addr", data_addr, 32'h400);
      tick();
      drive(0,0,4'h0,32'h0,0,0,0,0,0);
      #1;
      chk("t5_reissue_rdata", readdataM, 32'h77777777);
      tick();

`ifdef DMEM_TIMEOUT_EN
      // T6: slave never accepts. The watchdog fires after 8 busy cycles.
      drive(1,0,4'h0,32'h500,0,0,0,0,0);
      tick();                                   // now ADDR
      drive(1,0,4'h0,32'h500,0,1,0,0,0);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("t6_req_%0d", i), {31'b0, data_req}, 32'h1);
         chk($sformatf("t6_err_%0d", i), {31'b0, bus_err}, 32'h0);
         tick();
      end
      #1;
      chk("t6_buserr", {31'b0, bus_err}, 32'h1);
      chk("t6_readdata", readdataM, 32'hDEADBEEF);
      chk("t6_stall", {31'b0, d_stall}, 32'h0);
      chk("t6_req_dropped", {31'b0, data_req}, 32'h0);
      drive(0,0,4'h0,32'h0,0,0,0,0,0);
      tick();
      chk("t6_err_sticky", {31'b0, bus_err}, 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
